// File: rtl/ale_pkg.sv
// Shared types and helpers for the atmospheric light estimator.
// Channel indices follow the tap packing order, so B occupies the LSBs.
package ale_pkg;

    localparam int unsigned CH_B = 0;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_R = 2;
    localparam int unsigned NCH  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StFinalize,
        StDivide,
        StPublish
    } ale_state_e;

    function automatic int unsigned frame_pix(int unsigned img_w, int unsigned img_h);
        return img_w * img_h;
    endfunction

    // LSB position of one colour channel of one tap inside the packed window
    function automatic int unsigned chan_lsb(int unsigned pw, int unsigned tap,
                                             int unsigned ch);
        return (tap * NCH + ch) * pw;
    endfunction

endpackage

// File: rtl/ale_recip_div.sv
// Restoring divider producing floor(2^INV_W / divisor), saturated to INV_W bits.
// It loads on start and asserts done for one cycle after INV_W+1 iterations.
module ale_recip_div #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned INV_W   = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PIXEL_W-1:0] divisor,
    output logic               done,
    output logic [INV_W-1:0]   quotient
);

    localparam int unsigned CNT_W = $clog2(INV_W + 2);
    localparam logic [CNT_W-1:0] ITERS = CNT_W'(INV_W + 1);

    logic [PIXEL_W-1:0] div_q;
    logic [PIXEL_W-1:0] rem_q;
    logic [INV_W:0]     quo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;

    logic [PIXEL_W:0] rem_sh;
    logic [PIXEL_W:0] rem_nx;
    logic             ge;

    always_comb begin
        // The dividend 2^INV_W has only its MSB set, which is shifted in first
        rem_sh = {rem_q, (cnt_q == ITERS)};
        ge     = (rem_sh >= {1'b0, div_q});
        rem_nx = ge ? (rem_sh - {1'b0, div_q}) : rem_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                div_q <= divisor;
                rem_q <= '0;
                quo_q <= '0;
                cnt_q <= ITERS;
            end else if (cnt_q != '0) begin
                rem_q  <= rem_nx[PIXEL_W-1:0];
                quo_q  <= {quo_q[INV_W-1:0], ge};
                cnt_q  <= cnt_q - 1'b1;
                done_q <= (cnt_q == CNT_W'(1));
            end
        end
    end

    // The remainder is always below the divisor, so its top bit stays clear
    logic unused_rem_msb;
    assign unused_rem_msb = rem_nx[PIXEL_W];

    assign done     = done_q;
    assign quotient = quo_q[INV_W] ? '1 : quo_q[INV_W-1:0];

endmodule

// File: rtl/ale_frame.sv
// Frame-continuous atmospheric light estimator: tracks the brightest dark-channel
// window per frame, optionally IIR-smooths it, and publishes A and its reciprocal.
module ale_frame
    import ale_pkg::*;
#(
    parameter int unsigned PIXEL_W      = 8,
    parameter int unsigned NTAPS        = 9,
    parameter int unsigned IMG_W        = 512,
    parameter int unsigned IMG_H        = 512,
    parameter int unsigned INV_W        = 14,
    parameter int unsigned SMOOTH_SHIFT = 2,
    parameter int unsigned A_FLOOR      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [NTAPS*3*PIXEL_W-1:0]   in_window,
    input  logic                         cfg_smooth_en,
    output logic [PIXEL_W-1:0]           A_R,
    output logic [PIXEL_W-1:0]           A_G,
    output logic [PIXEL_W-1:0]           A_B,
    output logic [INV_W-1:0]             Inv_A_R,
    output logic [INV_W-1:0]             Inv_A_G,
    output logic [INV_W-1:0]             Inv_A_B,
    output logic                         a_valid,
    output logic [15:0]                  frame_count,
    output logic                         overrun
);

    localparam int unsigned FRAME_PIX = frame_pix(IMG_W, IMG_H);
    localparam int unsigned BEAT_W    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_PIX - 1);

    typedef logic [PIXEL_W-1:0] pix_t;

    // Per-channel running minimum across the taps
    pix_t min_c [NCH][NTAPS];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        for (genvar t = 0; t < NTAPS; t++) begin : g_tap
            pix_t tap_v;
            assign tap_v = in_window[chan_lsb(PIXEL_W, t, c) +: PIXEL_W];
            if (t == 0) begin : g_first
                assign min_c[c][t] = tap_v;
            end else begin : g_next
                assign min_c[c][t] = (tap_v < min_c[c][t-1]) ? tap_v : min_c[c][t-1];
            end
        end
    end

    // Stage 1
    logic [BEAT_W-1:0] beat_q;
    logic              s1_valid_q;
    logic              s1_last_q;
    pix_t              s1_q [NCH];
    logic              is_last;

    assign is_last = in_valid && (beat_q == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            for (int c = 0; c < NCH; c++) s1_q[c] <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_last_q  <= is_last;
            if (in_valid) begin
                beat_q <= is_last ? '0 : beat_q + 1'b1;
                for (int c = 0; c < NCH; c++) s1_q[c] <= min_c[c][NTAPS-1];
            end
        end
    end

    // Stage 2
    pix_t run_max_q;
    pix_t cand_q [NCH];
    pix_t dark;
    pix_t best [NCH];
    logic better;
    logic frame_end;

    always_comb begin
        dark = s1_q[0];
        for (int c = 1; c < NCH; c++) begin
            if (s1_q[c] < dark) dark = s1_q[c];
        end
    end

    assign better    = s1_valid_q && (dark > run_max_q);
    assign frame_end = s1_valid_q && s1_last_q;

    always_comb begin
        for (int c = 0; c < NCH; c++) best[c] = better ? s1_q[c] : cand_q[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max_q <= '0;
            for (int c = 0; c < NCH; c++) cand_q[c] <= '0;
        end else if (frame_end) begin
            run_max_q <= '0;
            for (int c = 0; c < NCH; c++) cand_q[c] <= '0;
        end else if (better) begin
            run_max_q <= dark;
            for (int c = 0; c < NCH; c++) cand_q[c] <= s1_q[c];
        end
    end

    // Finalize arithmetic
    ale_state_e            state_q;
    logic                  first_frame_q;
    pix_t                  snap_q  [NCH];
    pix_t                  a_new_q [NCH];
    pix_t                  a_q     [NCH];
    logic [INV_W-1:0]      inv_q   [NCH];
    logic signed [PIXEL_W:0] diff  [NCH];
    logic signed [PIXEL_W:0] sum   [NCH];
    pix_t                  a_mix   [NCH];
    pix_t                  a_new   [NCH];

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            diff[c]  = $signed({1'b0, snap_q[c]}) - $signed({1'b0, a_q[c]});
            sum[c]   = $signed({1'b0, a_q[c]}) + (diff[c] >>> SMOOTH_SHIFT);
            a_mix[c] = (first_frame_q || !cfg_smooth_en) ? snap_q[c] : sum[c][PIXEL_W-1:0];
            a_new[c] = (a_mix[c] < pix_t'(A_FLOOR)) ? pix_t'(A_FLOOR) : a_mix[c];
        end
    end

    // The smoothed value always lands back in [0, 2^PIXEL_W)
    logic unused_sum_msb;
    assign unused_sum_msb = sum[0][PIXEL_W] ^ sum[1][PIXEL_W] ^ sum[2][PIXEL_W];

    // Dividers load the combinational A_new during FINALIZE
    logic                  div_start;
    logic [NCH-1:0]        div_done;
    logic [INV_W-1:0]      quo [NCH];

    assign div_start = (state_q == StFinalize);

    for (genvar c = 0; c < NCH; c++) begin : g_div
        ale_recip_div #(
            .PIXEL_W (PIXEL_W),
            .INV_W   (INV_W)
        ) u_div (
            .clk      (clk),
            .rst      (rst),
            .start    (div_start),
            .divisor  (a_new[c]),
            .done     (div_done[c]),
            .quotient (quo[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            first_frame_q <= 1'b1;
            a_valid       <= 1'b0;
            frame_count   <= '0;
            overrun       <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                snap_q[c]  <= '0;
                a_new_q[c] <= '0;
                a_q[c]     <= '0;
                inv_q[c]   <= '0;
            end
        end else begin
            a_valid <= 1'b0;
            if (frame_end && (state_q != StIdle)) overrun <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (frame_end) begin
                        for (int c = 0; c < NCH; c++) snap_q[c] <= best[c];
                        state_q <= StFinalize;
                    end
                end
                StFinalize: begin
                    for (int c = 0; c < NCH; c++) a_new_q[c] <= a_new[c];
                    state_q <= StDivide;
                end
                StDivide: begin
                    if (&div_done) begin
                        for (int c = 0; c < NCH; c++) begin
                            a_q[c]   <= a_new_q[c];
                            inv_q[c] <= quo[c];
                        end
                        a_valid       <= 1'b1;
                        frame_count   <= frame_count + 16'd1;
                        first_frame_q <= 1'b0;
                        state_q       <= StPublish;
                    end
                end
                StPublish: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    assign A_R     = a_q[CH_R];
    assign A_G     = a_q[CH_G];
    assign A_B     = a_q[CH_B];
    assign Inv_A_R = inv_q[CH_R];
    assign Inv_A_G = inv_q[CH_G];
    assign Inv_A_B = inv_q[CH_B];

endmodule

// File: tb/tb_ale_frame.sv
// Randomized self-checking bench for ale_frame with a frame-level reference model
// and a scoreboard that checks every published result and its latency.
module tb_ale_frame;

    localparam int PW    = 8;
    localparam int NT    = 9;
    localparam int IW    = 14;
    localparam int WIN_W = NT * 3 * PW;
    localparam int FP8   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid, cfg_smooth_en;
    logic [WIN_W-1:0] in_window;
    logic [PW-1:0]    A_R, A_G, A_B;
    logic [IW-1:0]    Inv_A_R, Inv_A_G, Inv_A_B;
    logic             a_valid, overrun;
    logic [15:0]      frame_count;

    logic             in_valid4, cfg_smooth_en4;
    logic [WIN_W-1:0] in_window4;
    logic [PW-1:0]    A_R4, A_G4, A_B4;
    logic [IW-1:0]    Inv_A_R4, Inv_A_G4, Inv_A_B4;
    logic             a_valid4, overrun4;
    logic [15:0]      frame_count4;

    ale_frame #(
        .PIXEL_W(PW), .NTAPS(NT), .IMG_W(8), .IMG_H(8), .INV_W(IW),
        .SMOOTH_SHIFT(2), .A_FLOOR(1)
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_window(in_window),
        .cfg_smooth_en(cfg_smooth_en), .A_R(A_R), .A_G(A_G), .A_B(A_B),
        .Inv_A_R(Inv_A_R), .Inv_A_G(Inv_A_G), .Inv_A_B(Inv_A_B),
        .a_valid(a_valid), .frame_count(frame_count), .overrun(overrun)
    );

    ale_frame #(
        .PIXEL_W(PW), .NTAPS(NT), .IMG_W(4), .IMG_H(4), .INV_W(IW),
        .SMOOTH_SHIFT(2), .A_FLOOR(1)
    ) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_window(in_window4),
        .cfg_smooth_en(cfg_smooth_en4), .A_R(A_R4), .A_G(A_G4), .A_B(A_B4),
        .Inv_A_R(Inv_A_R4), .Inv_A_G(Inv_A_G4), .Inv_A_B(Inv_A_B4),
        .a_valid(a_valid4), .frame_count(frame_count4), .overrun(overrun4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int     ar, ag, ab, ir, ig, ib, fc;
        longint cyc;
    } exp_t;

    logic [WIN_W-1:0] frm [FP8];
    exp_t             exp_q [$];
    int               m_prev [3];
    bit               m_first = 1'b1;
    int               m_fc = 0;
    longint           cyc = 0;
    bit               av_prev = 1'b0;
    int               pulses4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Channel order in model arrays: 0=R, 1=G, 2=B
    function automatic void win_mins(input logic [WIN_W-1:0] w, output int mn[3]);
        for (int c = 0; c < 3; c++) begin
            mn[c] = 255;
            for (int t = 0; t < NT; t++) begin
                int v;
                v = int'(w[t*24 + (2-c)*8 +: 8]);
                if (v < mn[c]) mn[c] = v;
            end
        end
    endfunction

    function automatic void frame_snapshot(output int snap[3]);
        int best, mn[3], dark;
        best = 0;
        snap = '{0, 0, 0};
        for (int b = 0; b < FP8; b++) begin
            win_mins(frm[b], mn);
            dark = mn[0];
            if (mn[1] < dark) dark = mn[1];
            if (mn[2] < dark) dark = mn[2];
            if (dark > best) begin
                best = dark;
                snap = mn;
            end
        end
    endfunction

    task automatic model_publish(input int snap[3], input bit smooth, input longint exp_cyc);
        exp_t e;
        int a[3], inv[3];
        for (int c = 0; c < 3; c++) begin
            if (m_first || !smooth) a[c] = snap[c];
            else a[c] = m_prev[c] + ((snap[c] - m_prev[c]) >>> 2);
            if (a[c] < 1) a[c] = 1;
            inv[c] = 16384 / a[c];
            if (inv[c] > 16383) inv[c] = 16383;
            m_prev[c] = a[c];
        end
        m_first = 1'b0;
        m_fc    = (m_fc + 1) % 65536;
        e = '{ar: a[0], ag: a[1], ab: a[2], ir: inv[0], ig: inv[1], ib: inv[2],
              fc: m_fc, cyc: exp_cyc};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (a_valid) begin
            check_eq("a_valid pulse", av_prev, 0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected a_valid", a_valid, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("A_R", A_R, e.ar);
                check_eq("A_G", A_G, e.ag);
                check_eq("A_B", A_B, e.ab);
                check_eq("Inv_A_R", Inv_A_R, e.ir);
                check_eq("Inv_A_G", Inv_A_G, e.ig);
                check_eq("Inv_A_B", Inv_A_B, e.ib);
                check_eq("frame_count", frame_count, e.fc);
                check_eq("publish cycle", cyc, e.cyc);
            end
        end
        av_prev = a_valid;
        if (a_valid4) pulses4++;
    end

    function automatic logic [WIN_W-1:0] uniform_win(input int r, input int g, input int b);
        logic [WIN_W-1:0] w;
        for (int t = 0; t < NT; t++) w[t*24 +: 24] = {8'(r), 8'(g), 8'(b)};
        return w;
    endfunction

    task automatic gen_uniform(input int r, input int g, input int b);
        for (int i = 0; i < FP8; i++) frm[i] = uniform_win(r, g, b);
    endtask

    task automatic gen_random(input int lo, input int hi);
        for (int i = 0; i < FP8; i++)
            for (int t = 0; t < NT; t++)
                frm[i][t*24 +: 24] = {8'($urandom_range(hi, lo)), 8'($urandom_range(hi, lo)),
                                      8'($urandom_range(hi, lo))};
    endtask

    // One tap carries the exact minima; the others are at least as large
    task automatic plant(input int beat, input int r, input int g, input int b);
        int t0;
        t0 = $urandom_range(NT - 1, 0);
        for (int t = 0; t < NT; t++) begin
            if (t == t0) frm[beat][t*24 +: 24] = {8'(r), 8'(g), 8'(b)};
            else frm[beat][t*24 +: 24] = {8'($urandom_range(255, r)), 8'($urandom_range(255, g)),
                                          8'($urandom_range(255, b))};
        end
    endtask

    // Called and returns at a negedge; the last beat is sampled one edge before return
    task automatic drive8(input bit smooth, input bit gaps, input bit keep_valid,
                          input bit expect_pub);
        int snap[3];
        cfg_smooth_en = smooth;
        for (int b = 0; b < FP8; b++) begin
            if (gaps && $urandom_range(7, 0) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid  = 1'b1;
            in_window = frm[b];
            @(negedge clk);
        end
        if (!keep_valid) in_valid = 1'b0;
        frame_snapshot(snap);
        if (expect_pub) model_publish(snap, smooth, cyc + 18);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("scoreboard drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; in_window = '0; cfg_smooth_en = 1'b0;
        in_valid4 = 1'b0; in_window4 = '0; cfg_smooth_en4 = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset A_R", A_R, 0);
        check_eq("reset A_G", A_G, 0);
        check_eq("reset A_B", A_B, 0);
        check_eq("reset Inv_A_R", Inv_A_R, 0);
        check_eq("reset Inv_A_G", Inv_A_G, 0);
        check_eq("reset Inv_A_B", Inv_A_B, 0);
        check_eq("reset a_valid", a_valid, 0);
        check_eq("reset frame_count", frame_count, 0);
        check_eq("reset overrun", overrun, 0);
        check_eq("reset overrun4", overrun4, 0);
        rst = 1'b0;
        @(negedge clk);

        gen_uniform(200, 150, 100);
        drive8(1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check_eq("uniform A_R", A_R, 200);
        check_eq("uniform Inv_A_R", Inv_A_R, 81);
        check_eq("uniform Inv_A_G", Inv_A_G, 109);
        check_eq("uniform Inv_A_B", Inv_A_B, 163);
        check_eq("uniform frame_count", frame_count, 1);

        gen_random(0, 100);
        plant(10, 250, 240, 230);
        plant(20, 255, 255, 220);
        plant(30, 231, 230, 240);
        drive8(1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain();
        check_eq("tie A_R", A_R, 250);
        check_eq("tie A_G", A_G, 240);
        check_eq("tie A_B", A_B, 230);

        gen_uniform(200, 200, 200);
        drive8(1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain();
        gen_uniform(100, 100, 100);
        drive8(1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check_eq("smooth A_R", A_R, 175);
        check_eq("smooth Inv_A_R", Inv_A_R, 93);
        gen_uniform(255, 255, 255);
        drive8(1'b1, 1'b1, 1'b0, 1'b1);
        wait_drain();
        check_eq("smooth2 A_G", A_G, 195);

        repeat (4) begin
            int lo, hi;
            lo = $urandom_range(60, 0);
            hi = $urandom_range(255, lo);
            gen_random(lo, hi);
            drive8(1'($urandom_range(1, 0)), 1'b1, 1'b0, 1'b1);
            wait_drain();
        end

        gen_uniform(0, 0, 0);
        drive8(1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check_eq("floor A_B", A_B, 1);
        check_eq("floor Inv_A_B", Inv_A_B, 16383);

        gen_uniform(0, 0, 0);
        plant(37, 128, 128, 128);
        drive8(1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain();
        check_eq("single Inv_A_G", Inv_A_G, 128);

        gen_random(0, 200);
        drive8(1'b1, 1'b0, 1'b1, 1'b1);
        gen_random(100, 255);
        drive8(1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check_eq("continuous overrun", overrun, 0);

        gen_random(0, 255);
        drive8(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("mid-reset A_R", A_R, 0);
        check_eq("mid-reset Inv_A_B", Inv_A_B, 0);
        check_eq("mid-reset frame_count", frame_count, 0);
        check_eq("mid-reset a_valid", a_valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_first = 1'b1;
        m_fc = 0;
        m_prev = '{0, 0, 0};
        repeat (25) @(negedge clk);
        check_eq("post-reset no publish", frame_count, 0);
        gen_uniform(60, 70, 80);
        drive8(1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check_eq("post-reset A_R", A_R, 60);
        check_eq("post-reset frame_count", frame_count, 1);

        for (int b = 0; b < 32; b++) begin
            in_valid4  = 1'b1;
            in_window4 = (b < 16) ? uniform_win(50, 60, 70) : uniform_win(90, 90, 90);
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("overrun pulses", pulses4, 1);
        check_eq("overrun A_R", A_R4, 50);
        check_eq("overrun A_G", A_G4, 60);
        check_eq("overrun A_B", A_B4, 70);
        check_eq("overrun flag", overrun4, 1);
        check_eq("overrun frame_count", frame_count4, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
